// File: rtl/clk_ena_monitor.sv
// clk_ena_monitor: receive-side checker for the clock-enable bundle
// (sam_clk_ena, sym_clk_ena, clk_phase).
// It recovers symbol timing from sym_clk_ena and runs a local phase counter.
// Each input is checked against that counter. Mismatches produce one-cycle
// error flags. Lock is reported after LOCK_SYMS clean symbols.
// Error cycles seen while locked are counted in a saturating counter.

module clk_ena_monitor #(
  parameter int SAM_PERIOD  = 4,   // sys_clk cycles per sample enable, divides SYM_PERIOD
  parameter int SYM_PERIOD  = 16,  // sys_clk cycles per symbol enable, power of two <= 16
  parameter int LOCK_SYMS   = 2,   // clean symbols needed before locked asserts (1..15)
  parameter int ERR_CNT_W   = 8,   // width of the saturating error counter
  parameter int CHECK_PHASE = 1    // 1: compare clk_phase, 0: ignore it
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic                 sam_clk_ena,
  input  logic                 sym_clk_ena,
  input  logic [3:0]           clk_phase,
  input  logic                 err_clr,
  output logic                 locked,
  output logic [3:0]           phase_est,
  output logic                 sam_err,
  output logic                 sym_err,
  output logic                 phase_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // SYM_PERIOD and SAM_PERIOD are powers of two, so "mod" reduces to a mask.
  localparam logic [3:0]           SYM_LAST = 4'(SYM_PERIOD - 1);
  localparam logic [3:0]           SAM_MASK = 4'(SAM_PERIOD - 1);
  localparam logic [3:0]           LOCK_TGT = 4'(LOCK_SYMS);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;

  state_t               state_q, state_d;
  logic [3:0]           phase_q, phase_d;
  logic [3:0]           good_q, good_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 sam_err_q, sam_err_d;
  logic                 sym_err_q, sym_err_d;
  logic                 phase_err_q, phase_err_d;
  logic                 locked_q, locked_d;

  logic                 exp_sam, exp_sym;
  logic                 mis_sam, mis_sym, mis_phase, any_mis;
  logic [3:0]           phase_inc, good_inc;

  // Expected enables from the local counter and per-input mismatch detection.
  always_comb begin
    exp_sam   = ((phase_q & SAM_MASK) == SAM_MASK);
    exp_sym   = (phase_q == SYM_LAST);
    mis_sam   = (sam_clk_ena != exp_sam);
    mis_sym   = (sym_clk_ena != exp_sym);
    mis_phase = (CHECK_PHASE != 0) && (clk_phase != phase_q);
    any_mis   = mis_sam | mis_sym | mis_phase;
    phase_inc = (phase_q == SYM_LAST) ? 4'd0 : phase_q + 4'd1;
    good_inc  = good_q + 4'd1;
  end

  // Next-state logic for the search / verify / locked tracker and error counter.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    good_d      = good_q;
    err_cnt_d   = err_cnt_q;
    sam_err_d   = 1'b0;
    sym_err_d   = 1'b0;
    phase_err_d = 1'b0;

    case (state_q)
      SEARCH: begin
        // Flags stay quiet and the counter holds until a symbol pulse appears.
        if (sym_clk_ena) begin
          phase_d = 4'd0;
          good_d  = 4'd0;
          state_d = VERIFY;
        end
      end
      default: begin
        phase_d     = phase_inc;
        sam_err_d   = mis_sam;
        sym_err_d   = mis_sym;
        phase_err_d = mis_phase;
        if (any_mis) begin
          // One count per bad cycle, however many flags fire together.
          if ((state_q == LOCKED) && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
          good_d = 4'd0;
          // A pulse in the offending sample is taken as the new timing reference.
          if (sym_clk_ena) begin
            phase_d = 4'd0;
            state_d = VERIFY;
          end else begin
            state_d = SEARCH;
          end
        end else if ((state_q == VERIFY) && exp_sym) begin
          good_d = good_inc;
          if (good_inc == LOCK_TGT) begin
            state_d = LOCKED;
          end
        end
      end
    endcase

    // A clear wins over an increment in the same cycle.
    if (err_clr) begin
      err_cnt_d = '0;
    end

    locked_d = (state_d == LOCKED);
  end

  // State and registered outputs; reset drops lock at once without a flag pulse.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q     <= SEARCH;
      phase_q     <= 4'd0;
      good_q      <= 4'd0;
      err_cnt_q   <= '0;
      sam_err_q   <= 1'b0;
      sym_err_q   <= 1'b0;
      phase_err_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      good_q      <= good_d;
      err_cnt_q   <= err_cnt_d;
      sam_err_q   <= sam_err_d;
      sym_err_q   <= sym_err_d;
      phase_err_q <= phase_err_d;
      locked_q    <= locked_d;
    end
  end

  assign locked    = locked_q;
  assign phase_est = phase_q;
  assign sam_err   = sam_err_q;
  assign sym_err   = sym_err_q;
  assign phase_err = phase_err_q;
  assign err_count = err_cnt_q;

endmodule
